// File: rtl/w_writeback_stage.sv
// M/W pipeline register with load extension and writeback-data selection.
// Drives the GRF write port (also the W-stage forwarding source) and a retired-instruction counter.
module w_writeback_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_W,
    input  logic             flush_W,
    input  logic             RegWrite_M,
    input  logic [4:0]       A3_M,
    input  logic [1:0]       WDSel_M,
    input  logic [2:0]       LoadType_M,
    input  logic [31:0]      ALUOut_M,
    input  logic [31:0]      MemRD_M,
    input  logic [31:0]      PC_M,
    output logic             RegWrite_W,
    output logic [4:0]       A3_W,
    output logic [31:0]      WD_W,
    output logic [31:0]      PC_W,
    output logic [CNT_W-1:0] retired_cnt
);

    logic             rw_q, rw_d;
    logic [4:0]       a3_q, a3_d;
    logic [1:0]       wdsel_q, wdsel_d;
    logic [2:0]       ldtype_q, ldtype_d;
    logic [31:0]      alu_q, alu_d;
    logic [31:0]      mem_q, mem_d;
    logic [31:0]      pc_q, pc_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;

    // Flush outranks stall; a flush leaves the retired count alone.
    always_comb begin
        rw_d          = rw_q;
        a3_d          = a3_q;
        wdsel_d       = wdsel_q;
        ldtype_d      = ldtype_q;
        alu_d         = alu_q;
        mem_d         = mem_q;
        pc_d          = pc_q;
        valid_d       = valid_q;
        retired_cnt_d = retired_cnt_q;
        if (flush_W) begin
            rw_d     = 1'b0;
            a3_d     = 5'd0;
            wdsel_d  = 2'd0;
            ldtype_d = 3'd0;
            alu_d    = 32'd0;
            mem_d    = 32'd0;
            pc_d     = RESET_PC;
            valid_d  = 1'b0;
        end else if (!stall_W) begin
            rw_d          = RegWrite_M;
            a3_d          = A3_M;
            wdsel_d       = WDSel_M;
            ldtype_d      = LoadType_M;
            alu_d         = ALUOut_M;
            mem_d         = MemRD_M;
            pc_d          = PC_M;
            valid_d       = 1'b1;
            retired_cnt_d = retired_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rw_q          <= 1'b0;
            a3_q          <= 5'd0;
            wdsel_q       <= 2'd0;
            ldtype_q      <= 3'd0;
            alu_q         <= 32'd0;
            mem_q         <= 32'd0;
            pc_q          <= RESET_PC;
            valid_q       <= 1'b0;
            retired_cnt_q <= '0;
        end else begin
            rw_q          <= rw_d;
            a3_q          <= a3_d;
            wdsel_q       <= wdsel_d;
            ldtype_q      <= ldtype_d;
            alu_q         <= alu_d;
            mem_q         <= mem_d;
            pc_q          <= pc_d;
            valid_q       <= valid_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;
    logic [31:0] wd_sel;

    // Halfword picks on off[1] only; unaligned off[0] is ignored.
    always_comb begin
        byte_sel = 8'd0;
        case (alu_q[1:0])
            2'd0:    byte_sel = mem_q[7:0];
            2'd1:    byte_sel = mem_q[15:8];
            2'd2:    byte_sel = mem_q[23:16];
            default: byte_sel = mem_q[31:24];
        endcase
        half_sel = alu_q[1] ? mem_q[31:16] : mem_q[15:0];

        load_ext = mem_q;
        case (ldtype_q)
            3'd1:    load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'd2:    load_ext = {24'd0, byte_sel};
            3'd3:    load_ext = {{16{half_sel[15]}}, half_sel};
            3'd4:    load_ext = {16'd0, half_sel};
            default: load_ext = mem_q;
        endcase

        wd_sel = alu_q;
        case (wdsel_q)
            2'd1:    wd_sel = load_ext;
            2'd2:    wd_sel = pc_q + 32'd8;
            default: wd_sel = alu_q;
        endcase
    end

    assign RegWrite_W  = rw_q & valid_q & (a3_q != 5'd0);
    assign A3_W        = a3_q;
    assign WD_W        = valid_q ? wd_sel : 32'd0;
    assign PC_W        = pc_q;
    assign retired_cnt = retired_cnt_q;

endmodule
